// File: rtl/adder_sum_accumulator_if.sv
// -----------------------------------------------------------------------------
// adder_sum_accumulator_if
//
// Bundles the sample handshake, batch control and result outputs of the
// adder_sum_accumulator block.
//
//   master : producer/consumer side (drives samples, ack, clear; reads results)
//   slave  : accumulator side
//
//   in_valid  adder result present on sum/cout
//   sum       adder sum bits [3:0]
//   cout      adder carry-out, bit 4 of the sample value
//   in_ready  accumulator can accept a sample
//   ack       consumer acknowledges a completed batch
//   clear     synchronous abort back to IDLE
//   acc       running or final total (ACC_W bits)
//   count     samples accepted in the current batch
//   done      batch complete, acc is final
//   ovf       sticky saturation flag for the current batch
// -----------------------------------------------------------------------------
interface adder_sum_accumulator_if #(
   parameter int ACC_W = 8
);
   logic             in_valid;
   logic [3:0]       sum;
   logic             cout;
   logic             in_ready;
   logic             ack;
   logic             clear;
   logic [ACC_W-1:0] acc;
   logic [3:0]       count;
   logic             done;
   logic             ovf;

   modport master (
      output in_valid, sum, cout, ack, clear,
      input  in_ready, acc, count, done, ovf
   );

   modport slave (
      input  in_valid, sum, cout, ack, clear,
      output in_ready, acc, count, done, ovf
   );
endinterface

// File: rtl/adder_sum_accumulator.sv
// -----------------------------------------------------------------------------
// adder_sum_accumulator
//
// Collects BATCH results of the 4-bit adder stage ({cout, sum}, 0..31) into a
// saturating running total, then holds the total with done=1 until the
// consumer acknowledges it.
//
// Parameters:
//   ACC_W  accumulator width, 6..8
//   BATCH  results per batch, 1..15
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   ena    tile enable; 0 freezes all state and blocks every handshake
//   bus    slave side of adder_sum_accumulator_if (samples, ack, clear,
//          in_ready, acc, count, done, ovf)
// -----------------------------------------------------------------------------
module adder_sum_accumulator #(
   parameter int ACC_W = 8,
   parameter int BATCH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   adder_sum_accumulator_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [3:0]       count_q, count_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic [ACC_W:0]   sample_v;
   logic [ACC_W:0]   sum_ext;
   logic             last_sample;

   // The sample is at most 31 and acc at most 2^ACC_W-1 with ACC_W >= 6, so
   // the sum fits in ACC_W+1 bits and its top bit is exactly "exceeds max".
   always_comb begin
      sample_v      = '0;
      sample_v[4:0] = {bus.cout, bus.sum};
   end

   assign sum_ext     = {1'b0, acc_q} + sample_v;
   assign accept      = ena && bus.in_valid && (state_q != DONE);
   assign last_sample = (count_q == 4'(BATCH - 1));

   // Next-state and datapath update. Priority: clear > ack > accept.
   always_comb begin
      // NOTE: every output of this block gets a default first so that no
      // path leaves a signal unassigned, which would infer a latch.
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;

      if (ena) begin
         if (bus.clear || (state_q == DONE && bus.ack)) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
         end else if (accept) begin
            if (sum_ext[ACC_W]) begin
               acc_d = '1;
               ovf_d = 1'b1;
            end else begin
               acc_d = sum_ext[ACC_W-1:0];
            end
            count_d = count_q + 4'd1;
            // In IDLE count is 0, so BATCH==1 goes straight to DONE here.
            state_d = last_sample ? DONE : ACCUM;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready = (state_q != DONE);
   assign bus.done     = (state_q == DONE);
   assign bus.acc      = acc_q;
   assign bus.count    = count_q;
   assign bus.ovf      = ovf_q;

endmodule

// File: doc/adder_sum_accumulator.md
# adder_sum_accumulator

- Downstream consumer of the 4-bit adder stage in the tt_um_sec_4bit_adder tile.
- Accepts each adder result ({cout, sum[3:0]}, value 0..31) on a valid/ready handshake.
- Accumulates a fixed-size batch of results into a saturating running total, then holds the total with a done flag until acknowledged.
- Drives the total onto the tile's dedicated outputs.

## Interface

Parameters:
- ACC_W, default 8: accumulator width; legal range 6..8.
- BATCH, default 8: results per batch; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  tile enable; when 0, state is frozen and no handshake completes.
- in_valid  input  1  adder result present on sum/cout.
- sum  input  4  adder sum bits.
- cout  input  1  adder carry-out; forms bit 4 of the sample value.
- in_ready  output  1  block can accept a sample.
- ack  input  1  consumer acknowledges a completed batch.
- clear  input  1  synchronous abort; returns the block to IDLE.
- acc  output  ACC_W  running or final total.
- count  output  4  samples accepted in the current batch.
- done  output  1  batch complete; acc is final.
- ovf  output  1  sticky; the total saturated during this batch.

## Operation

- Sample value: v = {cout, sum}, zero-extended to ACC_W+1 bits.
- Accept: on a rising edge where ena && in_valid && in_ready.
- Update on accept:
  - acc <= min(acc + v, 2^ACC_W-1).
  - ovf <= ovf | (acc + v > 2^ACC_W-1).
  - count <= count + 1.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: acc, count and ovf are 0. An accept moves to ACCUM, or directly to DONE if BATCH==1.
  - ACCUM: an accept with count == BATCH-1 moves to DONE. Any other accept stays in ACCUM.
  - DONE: done=1 and in_ready=0. in_valid is ignored and acc, count and ovf are held. ack moves to IDLE and zeroes acc, count and ovf.
- clear (when ena=1), from any state: moves to IDLE and zeroes acc, count and ovf.
- Priority: clear > ack > accept.
  - clear together with in_valid: the sample is dropped.
  - ack outside DONE: ignored.
- ena=0: no transitions, no accepts, and no clear/ack effect. Outputs hold their values.
- Asynchronous reset: state=IDLE; acc=0, count=0, done=0, ovf=0, in_ready=1. A reset asserted mid-batch discards the batch immediately, with no clock required.

## Timing

- in_ready is combinational: (state != DONE).
- acc, count, ovf and done are registered.
- Latency: acc, count and ovf reflect an accepted sample one cycle after the accepting edge.
- done rises in the cycle after the edge that accepts the BATCH-th sample. That is the same cycle acc becomes final.
- Back-to-back accepts are allowed every cycle: throughput is 1 sample/cycle while ACCUM.
- ack sampled in DONE: done=0, acc=0 and in_ready=1 in the next cycle. A sample may be accepted on the edge after that.
- Saturation is evaluated on the same accept edge. ovf and the clamped acc appear together.

## Test plan

- Reset:
  - Assert rst_n=0 mid-batch with no clock edge.
  - Required: acc=0, count=0, done=0, ovf=0 and in_ready=1 immediately.
- Full batch (ACC_W=8, BATCH=8):
  - Send 8 consecutive samples of cout=1, sum=4'hF (v=31).
  - Required: acc=0xF8, count=8, done=1 and ovf=0 one cycle after the 8th accept.
  - Required: in_ready=0 in that same cycle.
- Saturation (ACC_W=7, BATCH=8):
  - Send samples of v=31.
  - Required: acc=31, 62, 93, 124, then 127 with ovf=1 after the 5th.
  - Required: acc=127 and ovf=1 held through done.
- Backpressure and ack:
  - In DONE with acc=0xF8, drive in_valid=1 with v=3 for 4 cycles.
  - Required: acc stays 0xF8 and count stays 8.
  - Pulse ack. Required next cycle: done=0, acc=0, count=0, in_ready=1.
- Clear priority:
  - Send 3 samples of v=5 (acc=15, count=3).
  - Assert clear and in_valid (v=7) on the same edge.
  - Required next cycle: acc=0, count=0, IDLE.
- ena gating:
  - Hold ena=0 while driving in_valid, ack and clear.
  - Required: no change to acc or count.
  - Raise ena with a v=9 sample. Required: acc=9 and count=1 next cycle.
